// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, register IDs
// and the fetch-stage state encoding.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_STOP = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/y86_instr_split.sv
// Combinational splitter: carves the 10-byte window at pc into instruction
// fields, checks encoding validity and computes the fall-through PC.
module y86_instr_split
  import y86_pkg::*;
(
  input  logic [79:0] bytes_i,
  input  logic [63:0] pc_i,
  output logic [3:0]  icode_o,
  output logic [3:0]  ifun_o,
  output logic [3:0]  ra_o,
  output logic [3:0]  rb_o,
  output logic [63:0] valc_o,
  output logic [63:0] valp_o,
  output logic        instr_valid_o,
  output logic        need_regids_o,
  output logic        need_valc_o
);

  logic ifun_ok;

  always_comb begin
    icode_o = bytes_i[7:4];
    ifun_o  = bytes_i[3:0];

    unique case (icode_o)
      I_RRMOVQ, I_JXX: ifun_ok = (ifun_o <= 4'd6);
      I_OPQ:           ifun_ok = (ifun_o <= 4'd3);
      default:         ifun_ok = (ifun_o == 4'd0);
    endcase
    instr_valid_o = (icode_o <= I_POPQ) && ifun_ok;

    unique case (icode_o)
      I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:
        need_regids_o = 1'b1;
      default:
        need_regids_o = 1'b0;
    endcase

    unique case (icode_o)
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL: need_valc_o = 1'b1;
      default:                                     need_valc_o = 1'b0;
    endcase

    if (need_regids_o) begin
      ra_o = bytes_i[15:12];
      rb_o = bytes_i[11:8];
    end else begin
      ra_o = REG_NONE;
      rb_o = REG_NONE;
    end

    // The constant follows the register byte when there is one.
    if (!need_valc_o)       valc_o = '0;
    else if (need_regids_o) valc_o = bytes_i[79:16];
    else                    valc_o = bytes_i[71:8];

    valp_o = pc_i + 64'd1 + {63'd0, need_regids_o} + (need_valc_o ? 64'd8 : 64'd0);
  end

endmodule

// File: rtl/y86_fetch.sv
// Y86-64 SEQ fetch stage: PC register, run/stop FSM with latched status,
// retired-instruction counter and the bubble mux applied once stopped.
module y86_fetch
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_en,
  input  logic [63:0] new_pc,
  input  logic [79:0] imem_data,
  input  logic        imem_error,
  output logic [63:0] imem_addr,
  output logic [63:0] pc,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [2:0]  stat,
  output logic [63:0] retired
);

  fetch_state_t state_q;
  logic [63:0]  pc_q;
  logic [63:0]  retired_q;
  logic [2:0]   stat_q;
  logic [2:0]   stat_comb;

  logic [3:0]   split_icode, split_ifun, split_ra, split_rb;
  logic [63:0]  split_valc, split_valp;
  logic         instr_valid, need_regids, need_valc;

  y86_instr_split u_split (
    .bytes_i       (imem_data),
    .pc_i          (pc_q),
    .icode_o       (split_icode),
    .ifun_o        (split_ifun),
    .ra_o          (split_ra),
    .rb_o          (split_rb),
    .valc_o        (split_valc),
    .valp_o        (split_valp),
    .instr_valid_o (instr_valid),
    .need_regids_o (need_regids),
    .need_valc_o   (need_valc)
  );

  always_comb begin
    if (imem_error)        stat_comb = STAT_ADR;
    else if (!instr_valid) stat_comb = STAT_INS;
    else if (split_icode == I_HALT) stat_comb = STAT_HLT;
    else                   stat_comb = STAT_AOK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RUN;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      stat_q    <= STAT_AOK;
    end else begin
      unique case (state_q)
        S_RUN: begin
          // A faulting or halting fetch wins over a same-cycle pc_en.
          if (stat_comb != STAT_AOK) begin
            state_q <= S_STOP;
            stat_q  <= stat_comb;
          end else if (pc_en) begin
            pc_q      <= new_pc;
            retired_q <= retired_q + 64'd1;
          end
        end
        S_STOP: begin
          state_q <= S_STOP;
        end
        default: state_q <= S_STOP;
      endcase
    end
  end

  always_comb begin
    imem_addr = pc_q;
    pc        = pc_q;
    retired   = retired_q;
    if (state_q == S_STOP) begin
      icode = I_NOP;
      ifun  = 4'h0;
      rA    = REG_NONE;
      rB    = REG_NONE;
      valC  = '0;
      valP  = pc_q;
      stat  = stat_q;
    end else begin
      icode = split_icode;
      ifun  = split_ifun;
      rA    = split_ra;
      rB    = split_rb;
      valC  = split_valc;
      valP  = split_valp;
      stat  = stat_comb;
    end
  end

  // Sanity on splitter outputs: absent fields must read as their defaults.
  always_comb begin
    if (rst_n) begin
      assert (need_valc || split_valc == '0);
      assert (need_regids || (split_ra == REG_NONE && split_rb == REG_NONE));
    end
  end

endmodule

// File: tb/tb_y86_fetch.sv
// Scoreboard bench for y86_fetch: stimulus queues hand-computed expectations,
// a monitor pops and compares them at each falling clock edge.
module tb_y86_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_en;
  logic [63:0] new_pc;
  logic [79:0] imem_data;
  logic        imem_error;
  logic [63:0] imem_addr, pc, valC, valP, retired;
  logic [3:0]  icode, ifun, rA, rB;
  logic [2:0]  stat;

  y86_fetch #(.RESET_PC(64'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_en      (pc_en),
    .new_pc     (new_pc),
    .imem_data  (imem_data),
    .imem_error (imem_error),
    .imem_addr  (imem_addr),
    .pc         (pc),
    .icode      (icode),
    .ifun       (ifun),
    .rA         (rA),
    .rB         (rB),
    .valC       (valC),
    .valP       (valP),
    .stat       (stat),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          is_dec;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp, pc, retired;
    logic [2:0]  stat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [79:0] le(input logic [79:0] be);
    logic [79:0] r;
    for (int unsigned i = 0; i < 10; i++)
      r[8*i +: 8] = be[8*(9-i) +: 8];
    return r;
  endfunction

  task automatic exp_dec(input string n, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [3:0] a, input logic [3:0] b, input logic [63:0] c,
                         input logic [63:0] p, input logic [2:0] s);
    exp_t e;
    e.name = n; e.is_dec = 1'b1;
    e.icode = ic; e.ifun = fn; e.ra = a; e.rb = b; e.valc = c; e.valp = p; e.stat = s;
    e.pc = '0; e.retired = '0;
    exp_q.push_back(e);
  endtask

  task automatic exp_st(input string n, input logic [63:0] p, input logic [2:0] s,
                        input logic [63:0] r);
    exp_t e;
    e.name = n; e.is_dec = 1'b0;
    e.pc = p; e.stat = s; e.retired = r;
    e.icode = '0; e.ifun = '0; e.ra = '0; e.rb = '0; e.valc = '0; e.valp = '0;
    exp_q.push_back(e);
  endtask

  function automatic void cmp(input string n, input string f, input logic [63:0] act,
                              input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %h, expected %h", n, f, act, req);
    end
  endfunction

  // Monitor: drains every expectation queued since the previous falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_dec) begin
          cmp(e.name, "icode", {60'd0, icode}, {60'd0, e.icode});
          cmp(e.name, "ifun",  {60'd0, ifun},  {60'd0, e.ifun});
          cmp(e.name, "rA",    {60'd0, rA},    {60'd0, e.ra});
          cmp(e.name, "rB",    {60'd0, rB},    {60'd0, e.rb});
          cmp(e.name, "valC",  valC, e.valc);
          cmp(e.name, "valP",  valP, e.valp);
          cmp(e.name, "stat",  {61'd0, stat},  {61'd0, e.stat});
        end else begin
          cmp(e.name, "pc",        pc,        e.pc);
          cmp(e.name, "imem_addr", imem_addr, e.pc);
          cmp(e.name, "stat",      {61'd0, stat}, {61'd0, e.stat});
          cmp(e.name, "retired",   retired,   e.retired);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Async reset pulse: asserted after a rising edge, checked at the falling
  // edge, released before the next rising edge.
  task automatic reset_pulse(input string n);
    step();
    rst_n = 1'b0; pc_en = 1'b0; imem_error = 1'b0;
    imem_data = le(80'h30F2_0001_0000_0000_0000);
    exp_st(n, 64'h0, 3'd1, 64'd0);
    exp_dec({n, "_dec"}, 4'h3, 4'h0, 4'hF, 4'h2, 64'h100, 64'hA, 3'd1);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    rst_n = 1'b0; pc_en = 1'b0; new_pc = '0; imem_error = 1'b0;
    imem_data = le(80'h30F2_0001_0000_0000_0000);
    #1;
    exp_st("reset", 64'h0, 3'd1, 64'd0);
    exp_dec("irmovq", 4'h3, 4'h0, 4'hF, 4'h2, 64'h100, 64'hA, 3'd1);

    step();
    rst_n = 1'b1; pc_en = 1'b1; new_pc = 64'hA;
    exp_st("pre_adv", 64'h0, 3'd1, 64'd0);

    step();
    pc_en = 1'b0;
    imem_data = le(80'h7040_0000_0000_0000_0000);
    exp_st("adv", 64'hA, 3'd1, 64'd1);
    exp_dec("jxx", 4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'h13, 3'd1);

    step();
    imem_data = le(80'h9000_0000_0000_0000_0000);
    exp_dec("ret", 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'hB, 3'd1);

    step();
    imem_data = le(80'h6312_0000_0000_0000_0000);
    exp_dec("opq", 4'h6, 4'h3, 4'h1, 4'h2, 64'h0, 64'hC, 3'd1);

    step();
    imem_data = le(80'h2634_0000_0000_0000_0000);
    exp_dec("cmov6", 4'h2, 4'h6, 4'h3, 4'h4, 64'h0, 64'hC, 3'd1);

    step();
    imem_data = le(80'h5012_0102_0304_0506_0708);
    exp_dec("mrmovq", 4'h5, 4'h0, 4'h1, 4'h2, 64'h0807_0605_0403_0201, 64'h14, 3'd1);

    step();
    imem_data = le(80'h0000_0000_0000_0000_0000);
    pc_en = 1'b1; new_pc = 64'h55;
    exp_dec("halt", 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'hB, 3'd2);
    exp_st("halt_st", 64'hA, 3'd2, 64'd1);

    step();
    imem_data = le(80'h30F2_0001_0000_0000_0000);
    exp_dec("bubble_hlt", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'hA, 3'd2);
    exp_st("stop_hlt", 64'hA, 3'd2, 64'd1);

    for (int k = 0; k < 5; k++) begin
      step();
      pc_en = 1'b1; new_pc = 64'h100 + 64'(k);
      exp_st("frozen", 64'hA, 3'd2, 64'd1);
    end

    reset_pulse("rst_in_stop");

    step();
    imem_data = le(80'h6412_0000_0000_0000_0000);
    exp_dec("ins_opq", 4'h6, 4'h4, 4'h1, 4'h2, 64'h0, 64'h2, 3'd4);
    exp_st("ins_st", 64'h0, 3'd4, 64'd0);
    step();
    exp_dec("bubble_ins", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd4);

    reset_pulse("rst2");
    step();
    imem_data = le(80'hC000_0000_0000_0000_0000);
    exp_dec("ins_c0", 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 3'd4);
    step();
    exp_st("stop_ins_c0", 64'h0, 3'd4, 64'd0);

    reset_pulse("rst3");
    step();
    imem_error = 1'b1;
    imem_data = le(80'h1000_0000_0000_0000_0000);
    exp_dec("adr", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 3'd3);
    step();
    imem_error = 1'b0;
    exp_dec("bubble_adr", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd3);

    reset_pulse("rst4");
    step();
    imem_data = le(80'h1000_0000_0000_0000_0000);
    pc_en = 1'b1; new_pc = ONES;
    exp_st("pre_wrap", 64'h0, 3'd1, 64'd0);
    step();
    pc_en = 1'b0;
    exp_st("top_pc", ONES, 3'd1, 64'd1);
    exp_dec("wrap", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
